// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory.
package imem_pkg;

    // Loader FSM encoding, fixed so debug dumps read the same across builds.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    // Length header size in bytes (little-endian 32-bit payload length).
    localparam int HDR_BYTES = 4;

    // Default instruction-memory geometry, shared with the memory itself.
    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DEPTH  = 1024;

endpackage

// File: rtl/imem_loader_hdr.sv
// Little-endian 4-byte length assembler. o_len is valid (combinationally) in the
// cycle the last header byte is accepted, so the FSM can branch on that same edge.
module imem_loader_hdr
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_beat,
    input  logic [7:0]  i_data,
    output logic [31:0] o_len,
    output logic        o_len_valid
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    // The fourth byte is taken straight from the input; only the first three are stored.
    assign o_len       = {i_data, r_shift};
    assign o_len_valid = i_beat && (r_cnt == 2'(HDR_BYTES - 1));

    // Shift accepted bytes in from the top so the first byte lands in bits [7:0].
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n || i_clr) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_beat) begin
            r_shift <= {i_data, r_shift[23:8]};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length header from a byte stream and writes
// the payload through a single-byte port, holding the CPU in reset until done.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int DEPTH     = IMEM_DEPTH,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    localparam logic [31:0] MAX_LEN = 32'(DEPTH - BASE_ADDR);
    localparam logic [31:0] BASE32  = 32'(BASE_ADDR);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_cpu_hold;
    logic [31:0]       r_idx;
    logic [31:0]       r_len;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        r_csum;
`endif

    logic        w_beat;
    logic        w_restart;
    logic [31:0] w_len;
    logic        w_len_valid;

    // in_ready is a register, so acceptance never depends combinationally on in_valid.
    assign w_beat    = in_valid && r_in_ready;
    assign w_restart = start && (r_state == IDLE || r_state == DONE || r_state == ERR);

    imem_loader_hdr u_hdr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_restart),
        .i_beat      (w_beat && (r_state == HDR)),
        .i_data      (in_data),
        .o_len       (w_len),
        .o_len_valid (w_len_valid)
    );

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign cpu_hold  = r_cpu_hold;

    // Load FSM with registered handshake, status and write-port outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: clearing r_mem_we here also drops a write whose beat landed on the reset edge.
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_hold  <= 1'b1;
            r_idx       <= '0;
            r_len       <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            // NOTE: default-low strobe each cycle makes mem_we a one-cycle pulse per beat.
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        r_state    <= HDR;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_cpu_hold <= 1'b1;
                        r_idx      <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                HDR: begin
                    if (w_len_valid) begin
                        r_len <= w_len;
                        r_idx <= '0;
                        if (w_len == 32'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
                            r_state    <= CSUM;
`else
                            r_state    <= DONE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
`endif
                        end else if (w_len > MAX_LEN) begin
                            r_state    <= ERR;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_beat) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= ADDR_W'(BASE32 + r_idx);
                        r_mem_wdata <= in_data;
                        r_idx       <= r_idx + 32'd1;
`ifdef IMEM_LOADER_CSUM_EN
                        r_csum      <= r_csum ^ in_data;
`endif
                        if (r_idx == r_len - 32'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
                            r_state    <= CSUM;
`else
                            r_state    <= DONE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                CSUM: begin
                    if (w_beat) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (in_data == r_csum) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule
